// File: rtl/instr_encoder_loader.sv
// Encoder side of the instruction decoder: builds RV32I words from field-level requests and
// writes them sequentially into instruction memory. Define ENC_READBACK_EN for a readback check.
module instr_encoder_loader #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DEPTH     = 64,
    parameter logic [31:0]       TERM_WORD = 32'hFFFF_FFFF,
    localparam int unsigned      CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [1:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [12:0]       req_imm,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [CNT_W-1:0]  word_count,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ENCODE = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
`ifdef ENC_READBACK_EN
    localparam logic [2:0] ST_VERIFY = 3'd5;
`endif

    localparam logic [2:0] KIND_R   = 3'd0;
    localparam logic [2:0] KIND_I   = 3'd1;
    localparam logic [2:0] KIND_LW  = 3'd2;
    localparam logic [2:0] KIND_SW  = 3'd3;
    localparam logic [2:0] KIND_BEQ = 3'd4;
    localparam logic [2:0] KIND_END = 3'd5;

    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_KIND  = 3'd1;
    localparam logic [2:0] ERR_RANGE = 3'd2;
    localparam logic [2:0] ERR_ODD   = 3'd3;
    localparam logic [2:0] ERR_FULL  = 3'd4;
`ifdef ENC_READBACK_EN
    localparam logic [2:0] ERR_RDBK  = 3'd5;
`endif

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    logic [2:0]       state_q, state_d;
    logic [2:0]       kind_q, kind_d;
    logic [1:0]       op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [12:0]      imm_q, imm_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [2:0]       code_q, code_d;
    logic             we_q, we_d;

    logic [2:0]  f3_alu;
    logic [6:0]  f7_alu;
    logic        imm_fits12;
    logic        beq_in_range;
    logic        is_full;
    logic        kind_illegal;
    logic [2:0]  enc_code;
    logic [31:0] enc_word;
    logic [31:0] word_r;
    logic [31:0] word_i;
    logic [31:0] word_lw;
    logic [31:0] word_sw;
    logic [31:0] word_beq;

    // Field encodings shared by R and I forms: op 1 selects SUB for R and is illegal for I.
    always_comb begin
        f3_alu = 3'b000;
        f7_alu = 7'b0000000;
        case (op_q)
            OP_SUB:  f7_alu = 7'b0100000;
            OP_AND:  f3_alu = 3'b111;
            OP_OR:   f3_alu = 3'b110;
            default: f3_alu = 3'b000;
        endcase
    end

    assign word_r   = {f7_alu, rs2_q, rs1_q, f3_alu, rd_q, OPC_R};
    assign word_i   = {imm_q[11:0], rs1_q, f3_alu, rd_q, OPC_I};
    assign word_lw  = {imm_q[11:0], rs1_q, 3'b010, rd_q, OPC_LW};
    assign word_sw  = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], OPC_SW};
    assign word_beq = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000, imm_q[4:1], imm_q[11],
                       OPC_BEQ};

    // A 13-bit value fits in 12 signed bits when its two top bits agree.
    assign imm_fits12   = (imm_q[12] == imm_q[11]);
    assign beq_in_range = (imm_q != 13'h0FFF);
    assign is_full      = (count_q == CNT_W'(DEPTH - 1));
    assign kind_illegal = (kind_q > KIND_END) || ((kind_q == KIND_I) && (op_q == OP_SUB));

    always_comb begin
        enc_code = ERR_NONE;
        if (kind_illegal) begin
            enc_code = ERR_KIND;
        end else if (is_full && (kind_q != KIND_END)) begin
            enc_code = ERR_FULL;
        end else if (((kind_q == KIND_I) || (kind_q == KIND_LW) || (kind_q == KIND_SW))
                     && !imm_fits12) begin
            enc_code = ERR_RANGE;
        end else if ((kind_q == KIND_BEQ) && !beq_in_range) begin
            enc_code = ERR_RANGE;
        end else if ((kind_q == KIND_BEQ) && imm_q[0]) begin
            enc_code = ERR_ODD;
        end
    end

    always_comb begin
        enc_word = '0;
        case (kind_q)
            KIND_R:   enc_word = word_r;
            KIND_I:   enc_word = word_i;
            KIND_LW:  enc_word = word_lw;
            KIND_SW:  enc_word = word_sw;
            KIND_BEQ: enc_word = word_beq;
            KIND_END: enc_word = TERM_WORD;
            default:  enc_word = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        wdata_d = wdata_q;
        count_d = count_q;
        done_d  = done_q;
        err_d   = 1'b0;
        code_d  = code_q;
        we_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    kind_d  = req_kind;
                    op_d    = req_op;
                    rd_d    = req_rd;
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    imm_d   = req_imm;
                    code_d  = ERR_NONE;
                    state_d = ST_ENCODE;
                end
            end
            ST_ENCODE: begin
                if (enc_code != ERR_NONE) begin
                    err_d   = 1'b1;
                    code_d  = enc_code;
                    state_d = ST_IDLE;
                end else begin
                    wdata_d = enc_word;
                    state_d = ST_SETUP;
                end
            end
            // Address and data are stable for a full cycle before the strobe.
            ST_SETUP: begin
                we_d    = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef ENC_READBACK_EN
                state_d = ST_VERIFY;
`else
                count_d = count_q + CNT_W'(1);
                if (kind_q == KIND_END) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
`endif
            end
`ifdef ENC_READBACK_EN
            // mem_addr still points at the word just written since count is not yet bumped.
            ST_VERIFY: begin
                count_d = count_q + CNT_W'(1);
                if (mem_rdata != wdata_q) begin
                    err_d  = 1'b1;
                    code_d = ERR_RDBK;
                end
                if (kind_q == KIND_END) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            kind_q  <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            wdata_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            we_q    <= we_d;
        end
    end

`ifndef ENC_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    assign req_ready  = (state_q == ST_IDLE) && !done_q;
    assign mem_we     = we_q;
    assign mem_addr   = BASE_ADDR + (ADDR_W'(count_q) << 2);
    assign mem_wdata  = wdata_q;
    assign word_count = count_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;

endmodule
